ctrl_pipe_unit: RTL
===================

# ctrl_pipe_unit

Pipelined main-control unit for the RISC-V pipeline CPU. It decodes the ID-stage opcode into the control bundle and registers it into the ID/EX boundary itself. It inserts bubbles on hazard or flush requests and sequences a multi-cycle MUL by holding EX and stalling the front end for a parametrised latency. A saturating bubble counter is kept for performance inspection.

## Interface
Parameters:
- OP_LEN, 7, opcode width
- ALUOP_LEN, 2, ALUOp width
- ALUOP_R / ALUOP_I / ALUOP_LSW / ALUOP_NO, 2'b10 / 2'b01 / 2'b00 / 2'b11, ALUOp encodings
- MUL_LAT, 3, extra EX cycles for MUL (0..15; 0 = single-cycle MUL)
- EXT_EN, 1, 1 = decode JAL (1101111); 0 = JAL falls to default row
- CNT_W, 16, bubble counter width

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  ID holds a valid instruction
- op_i  in  OP_LEN  ID opcode
- funct7_i  in  7  ID funct7 (MUL = 7'b0000001 with R-type)
- noop_i  in  1  hazard unit requests bubble (load-use)
- flush_i  in  1  taken-branch flush of the ID instruction
- ex_regwrite_o, ex_memtoreg_o, ex_memread_o, ex_memwrite_o, ex_alusrc_o, ex_branch_o, ex_jump_o  out  1 each  registered ID/EX control
- ex_aluop_o  out  ALUOP_LEN  registered ALUOp
- ex_mul_o  out  1  EX holds a MUL
- stall_o  out  1  hold PC and IF/ID (combinational from state)
- ex_hold_o  out  1  EX result not final; EX/MEM must capture a bubble
- bubble_cnt_o  out  CNT_W  saturating count of bubbles loaded

## Operation
- Decode table (op_i): 0110011 R: RegWrite, ALUOp=R; 0010011 I: RegWrite, ALUSrc, ALUOp=I; 0000011 lw: RegWrite, MemtoReg, MemRead, ALUSrc, ALUOp=LSW; 0100011 sw: MemWrite, ALUSrc, ALUOp=LSW; 1100011 beq: Branch, ALUSrc, ALUOp=I; 1101111 (EXT_EN=1) jal: RegWrite, Jump, ALUSrc, ALUOp=I; default: all 0, ALUOp=R. Unlisted bits are 0.
- MUL = R-type opcode and funct7_i=0000001; sets ex_mul_o.
- Bubble bundle: all 1-bit outputs 0, ex_aluop_o=ALUOP_NO.
- FSM states IDLE, MUL_WAIT; cnt is 4 bits.
- IDLE, each cycle: if flush_i or noop_i or !valid_i, load bubble and increment bubble_cnt_o (saturate at all-ones). Otherwise load decoded bundle. If loaded instruction is MUL and MUL_LAT>0, go MUL_WAIT, cnt=MUL_LAT.
- MUL_WAIT: stall_o=1, ex_hold_o=1, ID/EX bundle held unchanged, noop_i/flush_i/valid_i ignored, no counter increment. cnt decrements; when cnt==1, next edge returns to IDLE with ex_hold_o dropping. In that same edge, ID/EX still holds MUL; the next instruction loads one edge later.
- In IDLE: stall_o=0, ex_hold_o=0.
- Flush and noop together: single bubble, counter +1.
- Reset (any time, including mid-MUL_WAIT): immediately bubble bundle, ex_mul_o=0, state IDLE, cnt=0, stall_o=0, ex_hold_o=0, bubble_cnt_o=0.

## Timing
- Decode-to-output latency: 1 cycle (instruction in ID at edge N is visible on ex_* after edge N).
- MUL occupies EX for MUL_LAT+1 cycles: 1 load cycle, then MUL_LAT cycles with ex_hold_o=1. Front end is stalled for MUL_LAT cycles. The final cycle (ex_hold_o=0) is when EX/MEM captures the MUL.
- MUL_LAT=0: MUL behaves as any R-type; FSM never leaves IDLE.
- Back-to-back MULs: the second loads on the first IDLE cycle after MUL_WAIT, then re-enters MUL_WAIT.
- stall_o/ex_hold_o depend only on state (no input-to-output combinational path).

## Test plan
- Reset low: all ex_* 0, ex_aluop_o=2'b11, stall_o=0, bubble_cnt_o=0; release, feed add/addi/lw/sw/beq -> ex bundles match table one cycle later (lw: 1,1,1,0,aluop 00,alusrc 1).
- EXT_EN=1, op 1101111 -> ex_jump_o=1, regwrite=1, aluop=01; EXT_EN=0 -> all 0, aluop=10.
- noop_i and flush_i pulses, plus valid_i=0 cycle, and noop_i+flush_i together -> 4 bubbles, bubble_cnt_o=4.
- MUL_LAT=3, mul followed by add -> ex_mul_o=1 for 4 cycles; stall_o and ex_hold_o high for 3 of them; add appears the cycle after; flush_i pulsed during MUL_WAIT is ignored.
- Async reset asserted mid-MUL_WAIT (cnt=2) -> outputs bubble immediately without a clock, stall_o=0; after release, normal decode resumes.
- CNT_W=4, 20 consecutive bubbles -> bubble_cnt_o saturates at 15.

Source files
------------

// File: rtl/ctrl_pipe_unit_if.sv
// ID-stage control bundle between the front end and the main-control unit.
// The DUT side uses the slave modport; the ID/hazard side drives through master.
`timescale 1ns/1ps
interface ctrl_pipe_unit_if #(
    parameter int OP_LEN    = 7,
    parameter int ALUOP_LEN = 2,
    parameter int CNT_W     = 16
);
    // valid_i qualifies op_i/funct7_i for the current cycle; there is no ready:
    // while stall_o is high the front end must keep ID unchanged, and the unit
    // ignores valid_i/noop_i/flush_i until stall_o drops.
    logic                 valid_i;
    logic [OP_LEN-1:0]    op_i;
    logic [6:0]           funct7_i;
    logic                 noop_i;
    logic                 flush_i;

    logic                 ex_regwrite_o;
    logic                 ex_memtoreg_o;
    logic                 ex_memread_o;
    logic                 ex_memwrite_o;
    logic                 ex_alusrc_o;
    logic                 ex_branch_o;
    logic                 ex_jump_o;
    logic [ALUOP_LEN-1:0] ex_aluop_o;
    logic                 ex_mul_o;
    logic                 stall_o;
    logic                 ex_hold_o;
    logic [CNT_W-1:0]     bubble_cnt_o;
    logic                 dbgState;

    modport master (
        output valid_i, op_i, funct7_i, noop_i, flush_i,
        input  ex_regwrite_o, ex_memtoreg_o, ex_memread_o, ex_memwrite_o,
               ex_alusrc_o, ex_branch_o, ex_jump_o, ex_aluop_o, ex_mul_o,
               stall_o, ex_hold_o, bubble_cnt_o, dbgState
    );

    modport slave (
        input  valid_i, op_i, funct7_i, noop_i, flush_i,
        output ex_regwrite_o, ex_memtoreg_o, ex_memread_o, ex_memwrite_o,
               ex_alusrc_o, ex_branch_o, ex_jump_o, ex_aluop_o, ex_mul_o,
               stall_o, ex_hold_o, bubble_cnt_o, dbgState
    );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// Main-control decode registered into ID/EX, with bubble insertion, a
// multi-cycle MUL hold sequencer and a saturating bubble counter.
`timescale 1ns/1ps
module ctrl_pipe_unit #(
    parameter int                   OP_LEN    = 7,
    parameter int                   ALUOP_LEN = 2,
    parameter logic [ALUOP_LEN-1:0] ALUOP_R   = 2'b10,
    parameter logic [ALUOP_LEN-1:0] ALUOP_I   = 2'b01,
    parameter logic [ALUOP_LEN-1:0] ALUOP_LSW = 2'b00,
    parameter logic [ALUOP_LEN-1:0] ALUOP_NO  = 2'b11,
    parameter int                   MUL_LAT   = 3,
    parameter int                   EXT_EN    = 1,
    parameter int                   CNT_W     = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ctrl_pipe_unit_if.slave bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic                 regWrite;
        logic                 memToReg;
        logic                 memRead;
        logic                 memWrite;
        logic                 aluSrc;
        logic                 branch;
        logic                 jump;
        logic [ALUOP_LEN-1:0] aluOp;
        logic                 mul;
    } ctrl_t;

    localparam logic [OP_LEN-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_LEN-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_LEN-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_LEN-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_LEN-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_LEN-1:0] OP_JAL = 7'b1101111;
    localparam logic [6:0]        F7_MUL = 7'b0000001;
    localparam logic [3:0]        LAT    = 4'(MUL_LAT);
    localparam ctrl_t             BUBBLE = ctrl_t'({7'b0, ALUOP_NO, 1'b0});

    state_t           state, stateNext;
    logic [3:0]       cnt, cntNext;
    ctrl_t            exBundle, exNext, decoded;
    logic             bubbleReq, bubbleLoad;
    logic [CNT_W-1:0] bubbleCnt;

    always_comb begin
        decoded       = '0;
        decoded.aluOp = ALUOP_R;
        case (bus.op_i)
            OP_R: begin
                decoded.regWrite = 1'b1;
                decoded.mul      = (bus.funct7_i == F7_MUL);
            end
            OP_I: begin
                decoded.regWrite = 1'b1;
                decoded.aluSrc   = 1'b1;
                decoded.aluOp    = ALUOP_I;
            end
            OP_LW: begin
                decoded.regWrite = 1'b1;
                decoded.memToReg = 1'b1;
                decoded.memRead  = 1'b1;
                decoded.aluSrc   = 1'b1;
                decoded.aluOp    = ALUOP_LSW;
            end
            OP_SW: begin
                decoded.memWrite = 1'b1;
                decoded.aluSrc   = 1'b1;
                decoded.aluOp    = ALUOP_LSW;
            end
            OP_BEQ: begin
                decoded.branch = 1'b1;
                decoded.aluSrc = 1'b1;
                decoded.aluOp  = ALUOP_I;
            end
            OP_JAL: begin
                // Without the extension JAL stays on the default all-zero row.
                if (EXT_EN != 0) begin
                    decoded.regWrite = 1'b1;
                    decoded.jump     = 1'b1;
                    decoded.aluSrc   = 1'b1;
                    decoded.aluOp    = ALUOP_I;
                end
            end
            default: ;
        endcase
    end

    assign bubbleReq = bus.flush_i || bus.noop_i || !bus.valid_i;

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        exNext     = exBundle;
        bubbleLoad = 1'b0;
        case (state)
            IDLE: begin
                if (bubbleReq) begin
                    exNext     = BUBBLE;
                    bubbleLoad = 1'b1;
                end else begin
                    exNext = decoded;
                    if (decoded.mul && (LAT != 4'd0)) begin
                        stateNext = MUL_WAIT;
                        cntNext   = LAT;
                    end
                end
            end
            MUL_WAIT: begin
                // ID/EX keeps the MUL; the last hold edge returns to IDLE with it still loaded.
                if (cnt == 4'd1) begin
                    stateNext = IDLE;
                    cntNext   = 4'd0;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            exBundle  <= BUBBLE;
            bubbleCnt <= '0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            exBundle <= exNext;
            if (bubbleLoad && (bubbleCnt != {CNT_W{1'b1}}))
                bubbleCnt <= bubbleCnt + CNT_W'(1);
        end
    end

    assign bus.ex_regwrite_o = exBundle.regWrite;
    assign bus.ex_memtoreg_o = exBundle.memToReg;
    assign bus.ex_memread_o  = exBundle.memRead;
    assign bus.ex_memwrite_o = exBundle.memWrite;
    assign bus.ex_alusrc_o   = exBundle.aluSrc;
    assign bus.ex_branch_o   = exBundle.branch;
    assign bus.ex_jump_o     = exBundle.jump;
    assign bus.ex_aluop_o    = exBundle.aluOp;
    assign bus.ex_mul_o      = exBundle.mul;
    assign bus.stall_o       = (state == MUL_WAIT);
    assign bus.ex_hold_o     = (state == MUL_WAIT);
    assign bus.bubble_cnt_o  = bubbleCnt;
    assign bus.dbgState      = state;

endmodule
